multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 16-bit processor: sequences fetch/decode/execute/mem/writeback over a shared ALU and a single
//  unified memory port with ready handshake. Consumes opcode[15:12]/function_code[3:0] from the latched IR; drives datapath enables.
//  Replaces single-cycle control where memory has variable latency.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles mem_req may wait for mem_ready before HALT; 0 = watchdog disabled
//  TO_W         8    watchdog counter width; must hold MEM_TIMEOUT
// PORTS
//  clk              in   1  single clock, rising edge
//  reset            in   1  synchronous, active-high
//  run              in   1  1 = execute; sampled in IDLE and at each retire
//  opcode           in   4  IR[15:12], stable from DECODE until retire
//  function_code    in   4  IR[3:0], R-type ALU select
//  alu_zero         in   1  ALU result == 0
//  mem_ready        in   1  memory completes request this cycle
//  mem_req          out  1  memory request, held until mem_ready
//  mem_we           out  1  write strobe (sw only)
//  mem_addr_sel     out  1  0 = PC, 1 = ALU result
//  ir_write         out  1  load IR from memory data
//  pc_write         out  1  update PC
//  pc_src           out  2  0 = PC+2, 1 = branch target, 2 = jump target
//  reg_write        out  1  register file write enable
//  reg_dst          out  1  1 = rd (R-type), 0 = rt
//  reg_write_source out  1  1 = memory data, 0 = ALU
//  alu_source       out  1  1 = sign-extended immediate, 0 = register
//  alu_op           out  4  0000 add, 0001 sub, 0010 sll, 0011 and
//  instr_retired    out  1  one-cycle pulse per completed instruction
//  mem_timeout      out  1  sticky; watchdog expired
//  illegal_op       out  1  sticky; illegal instruction trapped (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE, watchdog=0, all outputs 0; takes effect next edge even mid-transaction (in-flight request abandoned).
//  Outputs are combinational from state+inputs; unlisted outputs = 0 in every state.
//  IDLE: run=1 -> FETCH.
//  FETCH: mem_req=1, mem_addr_sel=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0 -> DECODE; else stay.
//  DECODE (1 cycle): jmp(0110): pc_write=1, pc_src=2, retire. R(0000, func 0-3)/lw(0001)/sw(0010)/addi(0011)/beq(0100)/bne(0101)
//   -> EXEC. Opcodes 0111-1111 or R-type func 4-15 are illegal (see CONFIGURATION).
//  EXEC: R: alu_op=func -> WB. addi: alu_source=1, alu_op=0000 -> WB. lw/sw: alu_source=1, alu_op=0000 -> MEM.
//   beq: alu_op=0001, pc_src=1, pc_write=alu_zero, retire. bne: same, pc_write=!alu_zero, retire.
//  MEM: mem_req=1, mem_addr_sel=1, alu_source=1, alu_op=0000, mem_we=(sw). On mem_ready: sw retires; lw -> WB. Else stay.
//  WB (1 cycle): reg_write=1; R: reg_dst=1, alu_op=func; addi: alu_source=1; lw: reg_write_source=1. Retire.
//  Retire: instr_retired=1 that cycle; next state FETCH if run=1 else IDLE. run deasserted mid-instruction never aborts it.
//  Latency (mem_ready immediate): jmp 2, beq/bne 3, R/addi/sw 4, lw 5 cycles; each mem wait cycle adds 1.
//  Watchdog: cleared on entry to FETCH/MEM; +1 each cycle with mem_req=1 & mem_ready=0; reaching MEM_TIMEOUT -> HALT, mem_timeout=1.
//   mem_ready on the expiry cycle wins (completes normally).
//  HALT: all strobes 0, sticky flags held; exit only by reset.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal instruction in DECODE -> HALT, illegal_op=1 (sticky), no retire pulse.
//  Not defined: illegal instruction is a NOP: retire in DECODE (pc already advanced), illegal_op tied 0.
// STRUCTURE
//  Package proc16_pkg: opcode localparams (OP_RTYPE..OP_JMP), ALU op codes, FSM state enum
//   (IDLE,FETCH,DECODE,EXEC,MEM,WB,HALT).
//  Sub-module instr_class_decode: combinational opcode/function -> {is_r,is_lw,is_sw,is_addi,is_beq,is_bne,is_jmp,is_illegal}.
//  Top holds state register, watchdog counter, sticky flags, output decode.
// TESTING
//  1 reset=1 2 cycles, run=0 -> IDLE, all outputs 0 for 10 cycles, mem_req never set.
//  2 run=1, mem_ready=1, opcode 0000 func 0001 -> FETCH,DECODE,EXEC,WB; WB: reg_write=1, reg_dst=1, alu_op=0001; retire at cycle 4.
//  3 lw, mem_ready=0 for 3 cycles in MEM -> mem_req,mem_addr_sel held 3 cycles; WB reg_write_source=1; retire at cycle 8.
//  4 beq alu_zero=1 -> pc_write=1, pc_src=1; bne alu_zero=1 -> pc_write=0; both retire in EXEC.
//  5 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles, mem_timeout=1, mem_req=0; reset -> IDLE, flag cleared.
//  6 opcode 1111: with ILLEGAL_TRAP_EN -> HALT, illegal_op=1; without -> retire in DECODE, next FETCH, illegal_op=0.

Source files
------------

// File: rtl/proc16_pkg.sv
// Shared opcode, ALU-select and PC-source encodings plus the sequencer state type
// for the multi-cycle 16-bit processor control path.
package proc16_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_SW    = 4'h2;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_SLL = 4'h2;
    localparam logic [3:0] ALU_AND = 4'h3;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_e;

    typedef struct packed {
        logic is_r;
        logic is_lw;
        logic is_sw;
        logic is_addi;
        logic is_beq;
        logic is_bne;
        logic is_jmp;
        logic is_illegal;
    } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: opcode/function field to one-hot class flags.
// R-type is only legal for the four implemented ALU functions.
module instr_class_decode
    import proc16_pkg::*;
(
    input  logic [3:0]   opcode_i,
    input  logic [3:0]   function_code_i,
    output instr_class_t class_o
);

    always_comb begin
        class_o = '0;
        case (opcode_i)
            OP_RTYPE: begin
                if (function_code_i <= ALU_AND) class_o.is_r = 1'b1;
                else                            class_o.is_illegal = 1'b1;
            end
            OP_LW:   class_o.is_lw   = 1'b1;
            OP_SW:   class_o.is_sw   = 1'b1;
            OP_ADDI: class_o.is_addi = 1'b1;
            OP_BEQ:  class_o.is_beq  = 1'b1;
            OP_BNE:  class_o.is_bne  = 1'b1;
            OP_JMP:  class_o.is_jmp  = 1'b1;
            default: class_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM with memory watchdog.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal instruction halts and sets illegal_op).
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read from PC, waits for mem_ready
// DECODE | IR latched; jmp/illegal resolve here
// EXEC   | ALU operation; branches resolve here
// MEM    | data access at ALU address, waits for mem_ready
// WB     | register file write
// HALT   | watchdog or trap; exit only by reset
module multicycle_sequencer
    import proc16_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic [3:0] function_code,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       reg_write_source,
    output logic       alu_source,
    output logic [3:0] alu_op,
    output logic       instr_retired,
    output logic       mem_timeout,
    output logic       illegal_op
);

    state_e          state_q, state_d;
    logic [TO_W-1:0] wdog_q, wdog_d;
    logic [TO_W-1:0] wdog_inc;
    logic            wdog_expire;
    logic            timeout_q, timeout_d;
    logic            retire;
    instr_class_t    cls;

    instr_class_decode u_class (
        .opcode_i        (opcode),
        .function_code_i (function_code),
        .class_o         (cls)
    );

    assign wdog_inc    = wdog_q + TO_W'(1);
    assign wdog_expire = (MEM_TIMEOUT != 0) && (wdog_inc == TO_W'(MEM_TIMEOUT));

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        wdog_d           = '0;
        timeout_d        = timeout_q;
        retire           = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr_sel     = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = PC_SEQ;
        reg_write        = 1'b0;
        reg_dst          = 1'b0;
        reg_write_source = 1'b0;
        alu_source       = 1'b0;
        alu_op           = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
        illegal_d        = illegal_q;
`endif

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else begin
                    // Counter only runs while stalled, so it is zero on every entry to FETCH/MEM.
                    wdog_d = wdog_inc;
                    if (wdog_expire) begin
                        state_d   = HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            DECODE: begin
                if (cls.is_jmp) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    retire   = 1'b1;
                end else if (cls.is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d   = HALT;
                    illegal_d = 1'b1;
`else
                    retire = 1'b1;
`endif
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cls.is_r) begin
                    alu_op  = function_code;
                    state_d = WB;
                end else if (cls.is_addi) begin
                    alu_source = 1'b1;
                    state_d    = WB;
                end else if (cls.is_lw || cls.is_sw) begin
                    alu_source = 1'b1;
                    state_d    = MEM;
                end else begin
                    alu_op   = ALU_SUB;
                    pc_src   = PC_BRANCH;
                    pc_write = (cls.is_beq & alu_zero) | (cls.is_bne & ~alu_zero);
                    retire   = 1'b1;
                end
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                alu_source   = 1'b1;
                mem_we       = cls.is_sw;
                if (mem_ready) begin
                    if (cls.is_sw) retire  = 1'b1;
                    else           state_d = WB;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_expire) begin
                        state_d   = HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            WB: begin
                reg_write = 1'b1;
                if (cls.is_r) begin
                    reg_dst = 1'b1;
                    alu_op  = function_code;
                end
                alu_source       = cls.is_addi;
                reg_write_source = cls.is_lw;
                retire           = 1'b1;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        instr_retired = retire;
        if (retire) state_d = run ? FETCH : IDLE;
    end

    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: random instruction stream with per-instruction
// expected latency and retire-cycle strobes, plus directed reset, watchdog and illegal-op checks.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic [3:0] function_code;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       reg_write_source;
    logic       alu_source;
    logic [3:0] alu_op;
    logic       instr_retired;
    logic       mem_timeout;
    logic       illegal_op;

    multicycle_sequencer #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .opcode           (opcode),
        .function_code    (function_code),
        .alu_zero         (alu_zero),
        .mem_ready        (mem_ready),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr_sel     (mem_addr_sel),
        .ir_write         (ir_write),
        .pc_write         (pc_write),
        .pc_src           (pc_src),
        .reg_write        (reg_write),
        .reg_dst          (reg_dst),
        .reg_write_source (reg_write_source),
        .alu_source       (alu_source),
        .alu_op           (alu_op),
        .instr_retired    (instr_retired),
        .mem_timeout      (mem_timeout),
        .illegal_op       (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [16:0] sig;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Strobes observed on the retire cycle.
    function automatic logic [16:0] dut_sig();
        return {pc_write, pc_src, reg_write, reg_dst, reg_write_source, alu_source, alu_op,
                mem_we, mem_req, mem_addr_sel, ir_write, mem_timeout, illegal_op};
    endfunction

    function automatic logic [18:0] all_outs();
        return {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, reg_dst,
                reg_write_source, alu_source, alu_op, instr_retired, mem_timeout, illegal_op};
    endfunction

    // Per-instruction reference: cycles from first FETCH cycle to retire, and the retire-cycle strobes.
    function automatic exp_t model(input logic [3:0] op, input logic [3:0] fn, input logic z,
                                   input int wf, input int wm);
        exp_t       e;
        logic       pw, rw, rd, rws, as, we, mr, mas;
        logic [1:0] ps;
        logic [3:0] aop;
        pw = 0; rw = 0; rd = 0; rws = 0; as = 0; we = 0; mr = 0; mas = 0; ps = 0; aop = 0;
        e.lat = 2;
        if (op == 4'd0 && fn < 4'd4) begin
            e.lat = 4; rw = 1; rd = 1; aop = fn;
        end else if (op == 4'd1) begin
            e.lat = 5 + wm; rw = 1; rws = 1;
        end else if (op == 4'd2) begin
            e.lat = 4 + wm; we = 1; mr = 1; mas = 1; as = 1;
        end else if (op == 4'd3) begin
            e.lat = 4; rw = 1; as = 1;
        end else if (op == 4'd4 || op == 4'd5) begin
            e.lat = 3; ps = 2'd1; aop = 4'd1; pw = (op == 4'd4) ? z : !z;
        end else if (op == 4'd6) begin
            e.lat = 2; pw = 1; ps = 2'd2;
        end
        e.lat = e.lat + wf;
        e.sig = {pw, ps, rw, rd, rws, as, aop, we, mr, mas, 1'b0, 1'b0, 1'b0};
        return e;
    endfunction

    task automatic reset_dut();
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
        opcode = 4'h0; function_code = 4'h0; alu_zero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_instr(input logic [3:0] op, input logic [3:0] fn, input logic z,
                            input int wf, input int wm);
        int fc, mc, guard;
        bit done;
        exp_q.push_back(model(op, fn, z, wf, wm));
        opcode = op; function_code = fn; alu_zero = z;
        fc = 0; mc = 0; guard = 0; done = 0;
        while (!done) begin
            run = (guard == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (mem_req && !mem_addr_sel) begin
                mem_ready = (fc >= wf); fc++;
            end else if (mem_req && mem_addr_sel) begin
                mem_ready = (mc >= wm); mc++;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (instr_retired) done = 1;
            guard++;
            if (!done && guard > 60) begin
                n_cmp++; n_err++;
                $display("FAIL retire_wait: no retire after %0d cycles, expected within 60 (op %0h)", guard, op);
                done = 1;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    // Monitor: measures latency from FETCH start and checks strobes on each retire pulse.
    initial begin
        bit   in_instr;
        int   cyc;
        exp_t e;
        in_instr = 0; cyc = 0;
        forever begin
            @(negedge clk); #2;
            if (!mon_en) begin
                in_instr = 0; cyc = 0;
            end else begin
                if (!in_instr && mem_req && !mem_addr_sel) begin
                    in_instr = 1; cyc = 0;
                end
                if (in_instr) cyc++;
                if (instr_retired) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_retire: got retire pulse, expected none queued");
                    end else begin
                        e = exp_q.pop_front();
                        check("retire_latency", cyc, e.lat);
                        check("retire_strobes", {15'd0, dut_sig()}, {15'd0, e.sig});
                    end
                    in_instr = 0;
                end
            end
        end
    end

    initial begin
        int cnt;
        logic [3:0] op, fn;

        // Reset and idle with run low.
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            #1; check("idle_outputs", {13'd0, all_outs()}, 32'd0);
            @(negedge clk);
        end

        // Scoreboarded instruction stream: directed corners then random.
        mon_en = 1'b1;
        do_instr(4'h0, 4'h1, 1'b0, 0, 0);
        do_instr(4'h1, 4'h0, 1'b0, 0, 3);
        do_instr(4'h4, 4'h0, 1'b1, 0, 0);
        do_instr(4'h5, 4'h0, 1'b1, 0, 0);
        do_instr(4'h6, 4'h0, 1'b0, 0, 0);
        do_instr(4'h2, 4'h0, 1'b0, 3, 3);
        do_instr(4'h1, 4'h0, 1'b0, 3, 3);
        do_instr(4'h3, 4'h0, 1'b0, 1, 0);
`ifndef ILLEGAL_TRAP_EN
        do_instr(4'hF, 4'h0, 1'b0, 0, 0);
        do_instr(4'h0, 4'h9, 1'b0, 2, 0);
`endif
        for (int k = 0; k < 150; k++) begin
`ifdef ILLEGAL_TRAP_EN
            op = 4'($urandom_range(0, 6));
            fn = (op == 4'h0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
`else
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            fn = (op == 4'h0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
`endif
            do_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Fetch watchdog: exactly 4 stalled request cycles, then HALT with sticky flag.
        reset_dut();
        run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'b0; #1;
            if (mem_req) cnt++;
            @(negedge clk);
        end
        check("fetch_timeout_req_cycles", cnt, 4);
        #1; check("fetch_timeout_outputs", {13'd0, all_outs()}, 32'h2);
        reset_dut();
        #1; check("reset_clears_timeout", {13'd0, all_outs()}, 32'd0);

        // Data-access watchdog: lw fetch completes, MEM stalls forever.
        @(negedge clk);
        opcode = 4'h1; run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = mem_req && !mem_addr_sel; #1;
            if (mem_req && mem_addr_sel) cnt++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("mem_timeout_req_cycles", cnt, 4);
        #1; check("mem_timeout_flag", {31'd0, mem_timeout}, 32'd1);
        check("mem_timeout_req_low", {31'd0, mem_req}, 32'd0);

`ifdef ILLEGAL_TRAP_EN
        // Illegal opcode traps to HALT with no retire pulse.
        reset_dut();
        opcode = 4'hF; run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = mem_req; #1;
            if (instr_retired) cnt++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("illegal_no_retire", cnt, 0);
        #1; check("illegal_trap_outputs", {13'd0, all_outs()}, 32'h1);
        reset_dut();
        #1; check("reset_clears_illegal", {31'd0, illegal_op}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
